// File: rtl/mcrom_pkg.sv
// Shared definitions for the microcode control-store loader.
// Optional readback verify is enabled with MCROM_LOADER_VERIFY_EN.
package mcrom_pkg;

    localparam int MC_DATA_W    = 56;
    localparam int MC_ADDR_W    = 10;
    localparam int MC_NBYTES    = MC_DATA_W / 8;
    localparam int MC_MAX_WORDS = 1024;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE,
        VRD,
        VCMP
    } mc_state_e;

endpackage

// File: rtl/mcrom_word_asm.sv
// Byte-lane assembly register for one microinstruction, LSB byte first,
// with the lane index counter and the running 8-bit checksum.
module mcrom_word_asm
    import mcrom_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] data_o,
    output logic [7:0]        csum_o,
    output logic              last_o
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        csum_q, csum_d;

    assign last_o = accept && (idx_q == IDX_W'(NB - 1));
    assign data_o = data_q;
    assign csum_o = csum_q;

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        csum_d = csum_q;
        if (clr) begin
            idx_d  = '0;
            csum_d = '0;
        end else if (accept) begin
            for (int i = 0; i < NB; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    data_d[8*i +: 8] = byte_i;
                end
            end
            csum_d = csum_q + byte_i;
            // Index wraps on the last lane so the next word starts at lane 0
            idx_d  = last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            data_q <= '0;
            csum_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
            csum_q <= csum_d;
        end
    end

endmodule

// File: rtl/mcrom_loader.sv
// Host-side writer for the microcode control store: bytes in, 56-bit words out.
// Define MCROM_LOADER_VERIFY_EN to add a readback compare after every write.
module mcrom_loader
    import mcrom_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int ADDR_W = MC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        csum
`ifdef MCROM_LOADER_VERIFY_EN
    ,
    output logic              rd_ena,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
`endif
);

    mc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              err_q, err_d;
    logic              adv;
    logic              accept;
    logic              asm_clr;
    logic              asm_last;

    assign accept   = in_valid && (state_q == COLLECT);
    assign asm_clr  = start && (state_q == IDLE);

    assign in_ready = (state_q == COLLECT);
    assign wr_en    = (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign wr_addr  = addr_q;

`ifdef MCROM_LOADER_VERIFY_EN
    assign rd_ena   = (state_q == VRD);
    assign rd_addr  = addr_q;
`endif

    mcrom_word_asm #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr    (asm_clr),
        .accept (accept),
        .byte_i (in_data),
        .data_o (wr_data),
        .csum_o (csum),
        .last_o (asm_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (count == '0) begin
                        state_d = DONE;
                    end else if (count > (ADDR_W+1)'(MC_MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = base_addr;
                        rem_d   = count;
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (asm_last) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
`ifdef MCROM_LOADER_VERIFY_EN
                state_d = VRD;
`else
                adv = 1'b1;
`endif
            end
`ifdef MCROM_LOADER_VERIFY_EN
            VRD: begin
                state_d = VCMP;
            end
            VCMP: begin
                // A failed readback abandons the rest of the image
                if (rd_data != wr_data) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    adv = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (adv) begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == (ADDR_W+1)'(1)) ? DONE : COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mcrom_loader.sv
// Directed bench for mcrom_loader: table of load scenarios plus reset,
// restart and (with MCROM_LOADER_VERIFY_EN) readback-mismatch sequences.
module tb_mcrom_loader;

`ifdef MCROM_LOADER_VERIFY_EN
    localparam int WCYC = 10;
`else
    localparam int WCYC = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [55:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  csum;
`ifdef MCROM_LOADER_VERIFY_EN
    logic        rd_ena;
    logic [9:0]  rd_addr;
    logic [55:0] rd_data;
    logic [55:0] mem [0:1023];
    bit          corrupt_en = 1'b0;
    logic [9:0]  corrupt_addr = '0;
`endif

    always #5 clk = ~clk;

    mcrom_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .csum      (csum)
`ifdef MCROM_LOADER_VERIFY_EN
        ,
        .rd_ena    (rd_ena),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`endif
    );

`ifdef MCROM_LOADER_VERIFY_EN
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_ena) begin
            rd_data <= mem[rd_addr] ^
                ((corrupt_en && rd_addr == corrupt_addr) ? 56'h1 : 56'h0);
        end
    end
`endif

    typedef struct {
        logic [9:0]  base;
        logic [10:0] cnt;
        logic [7:0]  seed;
        bit          gaps;
        int          glitch_at;
        int          nfeed;
        int          exp_nwr;
        logic [9:0]  exp_first;
        logic [9:0]  exp_last;
        logic [55:0] exp_fdata;
        logic [55:0] exp_ldata;
        logic [7:0]  exp_csum;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ndone = 0;
    int done_cyc = 0;
    int bad_rdy = 0;
    bit ready_seen = 1'b0;
    logic [9:0]  wa_q [$];
    logic [55:0] wd_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (in_ready) bad_rdy++;
        end
        if (in_ready) ready_seen = 1'b1;
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ndone = 0;
        bad_rdy = 0;
        ready_seen = 1'b0;
    endtask

    task automatic run_load(input string tag, input vec_t v);
        int start_cyc;
        int t;
        int seq_bad;
        clear_log();
        start = 1'b1;
        base_addr = v.base;
        count = v.cnt;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < v.nfeed; k++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_data = v.seed + 8'(k);
            t = 0;
            while (!in_ready && ndone == 0 && t < 64) begin
                tick();
                t++;
            end
            if (!in_ready) break;
            if (k == v.glitch_at) begin
                start = 1'b1;
                base_addr = 10'h055;
                count = 11'd5;
            end
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        t = 0;
        while (ndone == 0 && t < 20000) begin
            tick();
            t++;
        end
        tick();
        tick();
        chk({tag, "_done_cnt"}, 64'(ndone), 64'd1);
        chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(v.exp_nwr));
        chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
        chk({tag, "_csum"}, 64'(csum), 64'(v.exp_csum));
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_rdy_in_write"}, 64'(bad_rdy), 64'd0);
        if (v.exp_nwr > 0 && wa_q.size() > 0) begin
            seq_bad = 0;
            for (int j = 1; j < wa_q.size(); j++) begin
                if (wa_q[j] != wa_q[j-1] + 10'd1) seq_bad++;
            end
            chk({tag, "_addr_seq"}, 64'(seq_bad), 64'd0);
            chk({tag, "_first_addr"}, 64'(wa_q[0]), 64'(v.exp_first));
            chk({tag, "_last_addr"}, 64'(wa_q[$]), 64'(v.exp_last));
            chk({tag, "_first_data"}, 64'(wd_q[0]), 64'(v.exp_fdata));
            chk({tag, "_last_data"}, 64'(wd_q[$]), 64'(v.exp_ldata));
            chk({tag, "_data_hold"}, 64'(wr_data), 64'(v.exp_ldata));
        end
        if (v.exp_lat >= 0) begin
            chk({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(v.exp_lat));
        end
        if (v.nfeed == 0) begin
            chk({tag, "_rdy_seen"}, 64'(ready_seen), 64'd0);
        end
    endtask

    vec_t tbl [7];
    vec_t v;

    initial begin
        tbl[0] = '{10'h010, 11'd1, 8'h01, 1'b0, -1, 7, 1, 10'h010, 10'h010,
                   56'h07060504030201, 56'h07060504030201, 8'h1C, 1'b0,
                   WCYC + 1};
        tbl[1] = '{10'h3FF, 11'd2, 8'h01, 1'b1, -1, 14, 2, 10'h3FF, 10'h000,
                   56'h07060504030201, 56'h0E0D0C0B0A0908, 8'h69, 1'b0, -1};
        tbl[2] = '{10'h123, 11'd0, 8'h00, 1'b0, -1, 0, 0, 10'h000, 10'h000,
                   56'h0, 56'h0, 8'h00, 1'b0, 1};
        tbl[3] = '{10'h123, 11'd1025, 8'h00, 1'b0, -1, 0, 0, 10'h000, 10'h000,
                   56'h0, 56'h0, 8'h00, 1'b1, 1};
        tbl[4] = '{10'h100, 11'd3, 8'hF0, 1'b0, -1, 21, 3, 10'h100, 10'h102,
                   56'hF6F5F4F3F2F1F0, 56'h0403020100FFFE, 8'h82, 1'b0,
                   3 * WCYC + 1};
        tbl[5] = '{10'h200, 11'd2, 8'h30, 1'b0, 4, 14, 2, 10'h200, 10'h201,
                   56'h36353433323130, 56'h3D3C3B3A393837, 8'hFB, 1'b0,
                   2 * WCYC + 1};
        tbl[6] = '{10'h005, 11'd1024, 8'h00, 1'b0, -1, 7168, 1024, 10'h005,
                   10'h004, 56'h06050403020100, 56'hFFFEFDFCFBFAF9, 8'h00,
                   1'b0, 1024 * WCYC + 1};

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        in_data = '0;
        in_valid = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_csum", 64'(csum), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_load($sformatf("v%0d", i), tbl[i]);
            repeat (2) tick();
        end

        clear_log();
        start = 1'b1;
        base_addr = 10'h020;
        count = 11'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hA0 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        chk("mrst_csum", 64'(csum), 64'd0);
        repeat (10) tick();
        chk("mrst_no_wr", 64'(wa_q.size()), 64'd0);
        v = '{10'h030, 11'd1, 8'h11, 1'b0, -1, 7, 1, 10'h030, 10'h030,
              56'h17161514131211, 56'h17161514131211, 8'h8C, 1'b0, WCYC + 1};
        run_load("after_rst", v);

`ifdef MCROM_LOADER_VERIFY_EN
        repeat (2) tick();
        corrupt_en = 1'b1;
        corrupt_addr = 10'h041;
        v = '{10'h040, 11'd3, 8'h50, 1'b0, -1, 21, 2, 10'h040, 10'h041,
              56'h56555453525150, 56'h5D5C5B5A595857, 8'hBB, 1'b1, -1};
        run_load("verify_bad", v);
        corrupt_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
